// File: rtl/wb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : wb_mem_arbiter
// Description : Two-master to one-slave Wishbone arbiter. It shares the core's
//               single memory port between instruction fetch (IF, read-only)
//               and the MEM-stage load/store port. A grant is held for the
//               whole transaction. Ties are broken round-robin. After reset
//               MEM wins the first tie.
// Revision    : 1.0 - initial release
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   defined   - an 8-bit watchdog ends a granted transaction with a one-cycle
//               error to the owner after TIMEOUT_CYCLES silent cycles.
//   undefined - no watchdog. A grant lasts until ack, err or abort.
//
// Parameters:
//   TIMEOUT_CYCLES : silent granted cycles before the forced error (1..255).
//                    Only used when WB_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i, rst_n_i              : clock (rising edge), async active-low reset
//   if_addr_i/cyc_i/stb_i       : IF fetch request
//   if_ack_o/err_o              : IF completion (only while IF is granted)
//   mem_addr_i/dat_i/sel_i/
//   mem_cyc_i/stb_i/we_i        : MEM load/store request
//   mem_ack_o/err_o             : MEM completion (only while MEM is granted)
//   wbm_addr_o/dat_o/sel_o/
//   wbm_cyc_o/stb_o/we_o        : shared Wishbone master outputs
//   wbm_ack_i/err_i             : shared Wishbone slave responses
//   gnt_o                       : 00 none, 01 IF, 10 MEM
// Bus read data is wired straight from the slave to both masters. This block
// has no read-data path.
//==============================================================================
module wb_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_cyc_i,
   input  logic        if_stb_i,
   output logic        if_ack_o,
   output logic        if_err_o,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_dat_i,
   input  logic [3:0]  mem_sel_i,
   input  logic        mem_cyc_i,
   input  logic        mem_stb_i,
   input  logic        mem_we_i,
   output logic        mem_ack_o,
   output logic        mem_err_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic [1:0]  gnt_o
);

   // The state encoding equals the gnt_o encoding.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_IF  = 2'b01,
      GNT_MEM = 2'b10
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t     state;
   logic       last_gnt;      // 0 = IF finished last, 1 = MEM finished last
   logic [1:0] gnt;

   logic if_req;
   logic mem_req;
   logic in_if;
   logic in_mem;
   logic bus_done;
   logic timeout_hit;

   assign if_req   = if_cyc_i & if_stb_i;
   assign mem_req  = mem_cyc_i & mem_stb_i;
   assign in_if    = (state == GNT_IF);
   assign in_mem   = (state == GNT_MEM);
   assign bus_done = wbm_ack_i | wbm_err_i;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // The count is held at zero in IDLE. Every grant therefore starts from 0.
   // While granted it counts cycles that had no slave response.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt <= 8'd0;
      end else if (state == IDLE) begin
         wait_cnt <= 8'd0;
      end else if (!bus_done) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // A real ack/err in the same cycle takes priority over the watchdog.
   assign timeout_hit = (state != IDLE) && (wait_cnt == TIMEOUT_LIMIT) && !bus_done;
`else
   logic unused_cfg;
   assign unused_cfg  = ^TIMEOUT_LIMIT;
   assign timeout_hit = 1'b0;
`endif

   // Arbitration FSM. gnt is registered next to state so that gnt_o
   // comes directly from a flop.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         last_gnt <= 1'b0;
         gnt      <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (if_req && mem_req) begin
                  // Round-robin: grant the master that did not finish last.
                  if (last_gnt) begin
                     state <= GNT_IF;
                     gnt   <= 2'b01;
                  end else begin
                     state <= GNT_MEM;
                     gnt   <= 2'b10;
                  end
               end else if (mem_req) begin
                  state <= GNT_MEM;
                  gnt   <= 2'b10;
               end else if (if_req) begin
                  state <= GNT_IF;
                  gnt   <= 2'b01;
               end
            end
            GNT_IF: begin
               // Response, watchdog expiry or abort (cyc dropped) ends the grant.
               if (!if_cyc_i || bus_done || timeout_hit) begin
                  state    <= IDLE;
                  gnt      <= 2'b00;
                  last_gnt <= 1'b0;
               end
            end
            GNT_MEM: begin
               if (!mem_cyc_i || bus_done || timeout_hit) begin
                  state    <= IDLE;
                  gnt      <= 2'b00;
                  last_gnt <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end

   assign gnt_o = gnt;

   // Bus request path: a combinational copy of the owner. In IDLE every
   // output is 0. The watchdog cycle removes cyc/stb from the bus.
   always_comb begin
      wbm_addr_o = 32'd0;
      wbm_dat_o  = 32'd0;
      wbm_sel_o  = 4'h0;
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      wbm_we_o   = 1'b0;
      if (in_if) begin
         wbm_addr_o = if_addr_i;
         wbm_sel_o  = 4'hF;
         wbm_cyc_o  = if_cyc_i & ~timeout_hit;
         wbm_stb_o  = if_stb_i & ~timeout_hit;
      end else if (in_mem) begin
         wbm_addr_o = mem_addr_i;
         wbm_dat_o  = mem_dat_i;
         wbm_sel_o  = mem_sel_i;
         wbm_cyc_o  = mem_cyc_i & ~timeout_hit;
         wbm_stb_o  = mem_stb_i & ~timeout_hit;
         wbm_we_o   = mem_we_i;
      end
   end

   // Response path: only the owner sees responses. When ack and err arrive
   // together, err wins.
   assign if_ack_o  = in_if  & wbm_ack_i & ~wbm_err_i;
   assign if_err_o  = in_if  & (wbm_err_i | timeout_hit);
   assign mem_ack_o = in_mem & wbm_ack_i & ~wbm_err_i;
   assign mem_err_o = in_mem & (wbm_err_i | timeout_hit);

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
module tb_wb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_dat = '0;
   logic [3:0]  mem_sel = '0;
   logic        if_cyc = 0, if_stb = 0, mem_cyc = 0, mem_stb = 0, mem_we = 0;
   logic        ack = 0, err = 0;
   logic        if_ack, if_err, mem_ack, mem_err;
   logic [31:0] wbm_addr, wbm_dat;
   logic [3:0]  wbm_sel;
   logic        wbm_cyc, wbm_stb, wbm_we;
   logic [1:0]  gnt;

   wb_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .if_addr_i(if_addr), .if_cyc_i(if_cyc), .if_stb_i(if_stb),
      .if_ack_o(if_ack), .if_err_o(if_err),
      .mem_addr_i(mem_addr), .mem_dat_i(mem_dat), .mem_sel_i(mem_sel),
      .mem_cyc_i(mem_cyc), .mem_stb_i(mem_stb), .mem_we_i(mem_we),
      .mem_ack_o(mem_ack), .mem_err_o(mem_err),
      .wbm_addr_o(wbm_addr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
      .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
      .wbm_ack_i(ack), .wbm_err_i(err), .gnt_o(gnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model. owner: 0 none, 1 IF, 2 MEM. last: owner that finished
   // last (1 after reset, so MEM wins the first tie). waited: silent cycles
   // so far in the current grant.
   int m_owner = 0;
   int m_last  = 1;
   int m_wait  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit timed_out();
`ifdef WB_ARB_TIMEOUT_EN
      return (m_owner != 0) && (m_wait == TO) && !ack && !err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs();
      bit to;
      bit oi;
      bit om;
      to = timed_out();
      oi = (m_owner == 1);
      om = (m_owner == 2);
      chk("gnt",  32'(gnt), 32'(m_owner));
      chk("addr", wbm_addr, oi ? if_addr : (om ? mem_addr : 32'd0));
      chk("dat",  wbm_dat,  om ? mem_dat : 32'd0);
      chk("sel",  32'(wbm_sel), oi ? 32'hF : (om ? 32'(mem_sel) : 32'd0));
      chk("we",   32'(wbm_we),  32'(om & mem_we));
      chk("cyc",  32'(wbm_cyc), 32'(((oi & if_cyc) | (om & mem_cyc)) & !to));
      chk("stb",  32'(wbm_stb), 32'(((oi & if_stb) | (om & mem_stb)) & !to));
      chk("if_ack",  32'(if_ack),  32'(oi & ack & !err));
      chk("if_err",  32'(if_err),  32'(oi & (err | to)));
      chk("mem_ack", 32'(mem_ack), 32'(om & ack & !err));
      chk("mem_err", 32'(mem_err), 32'(om & (err | to)));
   endtask

   // Check the current cycle, then advance one edge together with the model.
   // The caller drives inputs 1 time unit after the edge.
   task automatic tick();
      int  n_owner;
      int  n_last;
      int  n_wait;
      bit  to;
      bit  holding;
      #1;
      check_outputs();
      to      = timed_out();
      n_owner = m_owner;
      n_last  = m_last;
      n_wait  = m_wait;
      if (m_owner == 0) begin
         if (if_cyc && if_stb && mem_cyc && mem_stb) n_owner = 3 - m_last;
         else if (mem_cyc && mem_stb)                n_owner = 2;
         else if (if_cyc && if_stb)                  n_owner = 1;
         n_wait = 0;
      end else begin
         holding = (m_owner == 1) ? if_cyc : mem_cyc;
         if (ack || err || to || !holding) begin
            n_owner = 0;
            n_last  = m_owner;
         end else begin
            n_wait = m_wait + 1;
         end
      end
      @(posedge clk);
      m_owner = n_owner;
      m_last  = n_last;
      m_wait  = n_wait;
      #1;
   endtask

   task automatic idle_masters();
      if_cyc = 0; if_stb = 0; mem_cyc = 0; mem_stb = 0; ack = 0; err = 0;
   endtask

   initial begin
      // Reset state
      #2;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Both masters request right after reset: MEM first, then alternate
      if_addr = 32'h0000_0040; mem_addr = 32'h0000_1000; mem_sel = 4'hF;
      if_cyc = 1; if_stb = 1; mem_cyc = 1; mem_stb = 1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("rr_order", 32'(gnt), (k % 2 == 0) ? 32'd2 : 32'd1);
         ack = 1; tick();
         chk("dead_cycle", 32'(gnt), 32'd0);
         ack = 0; tick();
      end
      idle_masters(); tick(); tick();

      // IF-only fetch of 0x100. The slave acks 2 cycles after the grant.
      if_addr = 32'h0000_0100; if_cyc = 1; if_stb = 1;
      tick();
      chk("if_gnt", 32'(gnt), 32'd1);
      chk("if_sel", 32'(wbm_sel), 32'hF);
      chk("if_addr_bus", wbm_addr, 32'h0000_0100);
      tick(); tick();
      ack = 1; tick();
      ack = 0; if_cyc = 0; if_stb = 0; tick();

      // MEM store. Ack and err arrive in the same cycle.
      mem_addr = 32'h0000_2000; mem_dat = 32'hDEAD_BEEF; mem_sel = 4'b0011;
      mem_we = 1; mem_cyc = 1; mem_stb = 1;
      tick();
      chk("st_dat", wbm_dat, 32'hDEAD_BEEF);
      chk("st_sel", 32'(wbm_sel), 32'h3);
      ack = 1; err = 1;
      #1;
      chk("err_wins_err", 32'(mem_err), 32'd1);
      chk("err_wins_ack", 32'(mem_ack), 32'd0);
      tick();
      idle_masters(); mem_we = 0; tick();

      // IF aborts mid-grant. A stray ack in IDLE goes nowhere.
      if_cyc = 1; if_stb = 1;
      tick(); tick();
      if_cyc = 0; if_stb = 0;
      tick();
      chk("abort_idle", 32'(gnt), 32'd0);
      ack = 1;
      tick();
      ack = 0; tick();

      // Silent slave
      if_cyc = 1; if_stb = 1;
      tick();
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 0; i < TO; i++) tick();
      chk("to_err", 32'(if_err), 32'd1);
      chk("to_cyc", 32'(wbm_cyc), 32'd0);
      tick();
      chk("to_idle", 32'(gnt), 32'd0);
      idle_masters(); tick();
`else
      for (int i = 0; i < 305; i++) tick();
      chk("held", 32'(gnt), 32'd1);
      idle_masters(); tick(); tick();
`endif

      // Randomized traffic. Periods with a silent slave exercise long waits.
      begin
         bit silent;
         silent = 0;
         for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) silent = ($urandom_range(0, 3) == 0);
            if_cyc   = ($urandom_range(0, 3) != 0);
            if_stb   = if_cyc & ($urandom_range(0, 3) != 0);
            mem_cyc  = ($urandom_range(0, 2) != 0);
            mem_stb  = mem_cyc & ($urandom_range(0, 3) != 0);
            mem_we   = $urandom_range(0, 1) == 1;
            if_addr  = $urandom;
            mem_addr = $urandom & 32'hFFFF_FFFC;
            mem_dat  = $urandom;
            mem_sel  = 4'($urandom);
            ack      = !silent && ($urandom_range(0, 2) == 0);
            err      = !silent && ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      idle_masters(); tick();

      // Asynchronous reset during a grant
      mem_cyc = 1; mem_stb = 1;
      tick();
      chk("pre_rst_gnt", 32'(gnt), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_gnt", 32'(gnt), 32'd0);
      chk("async_cyc", 32'(wbm_cyc), 32'd0);
      m_owner = 0; m_last = 1; m_wait = 0;
      idle_masters();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      if_cyc = 1; if_stb = 1; mem_cyc = 1; mem_stb = 1;
      tick();
      chk("post_rst_tie", 32'(gnt), 32'd2);
      ack = 1; tick();
      idle_masters(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
